// File: rtl/act_buf_pkg.sv
// ---------------------------------------------------------------------------------------------
// act_buf_pkg
// Shared definitions for the activation-buffer controllers (read-side stream sequencer and the
// DMA write-side controller).
//   ACT_DATA_WIDTH / ACT_ADDR_WIDTH / ACT_CNT_W : default buffer geometry
//   act_stream_state_e                          : stream sequencer FSM states
//   act_desc_t                                  : tile descriptor {base, count, stride}
// ---------------------------------------------------------------------------------------------
package act_buf_pkg;

    localparam int unsigned ACT_DATA_WIDTH = 128;
    localparam int unsigned ACT_ADDR_WIDTH = 14;
    localparam int unsigned ACT_CNT_W      = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } act_stream_state_e;

    typedef struct packed {
        logic [ACT_ADDR_WIDTH-1:0] base;
        logic [ACT_CNT_W-1:0]      count;
        logic [ACT_ADDR_WIDTH-1:0] stride;
    } act_desc_t;

endpackage

// File: rtl/act_stream_fifo.sv
// ---------------------------------------------------------------------------------------------
// act_stream_fifo
// Synchronous first-word-fall-through FIFO. No handshake logic: the parent guarantees that a
// push never arrives while full without a matching pop. DEPTH must be a power of 2 (>= 2).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clear     : drop all entries (wins over push/pop)
//   i_push      : write i_wdata
//   i_pop       : remove head entry
//   o_rdata     : head entry (valid when !o_empty)
//   o_count     : number of stored entries
//   o_full      : count == DEPTH
//   o_empty     : count == 0
// ---------------------------------------------------------------------------------------------
module act_stream_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FullCnt);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty && !i_clear;
    assign w_push = i_push && (!o_full || w_pop) && !i_clear;

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/act_buf_stream_ctrl.sv
// ---------------------------------------------------------------------------------------------
// act_buf_stream_ctrl
// Read-side sequencer for activation-buffer port B. Walks a tile descriptor (base, count,
// stride), issues registered reads, captures returning words READ_LAT cycles later into an
// output FWFT FIFO and streams them out over valid/ready. A read is only launched when a FIFO
// slot is reserved for it (fifo_count + inflight < FIFO_DEPTH), so backpressure never drops data.
// Optional feature macro: ACT_STREAM_PERF_EN adds perf_stall_cnt / perf_starve_cnt.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   cfg_start                      : pulse, latch cfg_base/cfg_count/cfg_stride and start
//   cfg_base/cfg_count/cfg_stride  : tile descriptor
//   abort                          : pulse, cancel the running stream (no done)
//   busy                           : stream active (RUN or FLUSH)
//   done                           : pulse, cycle after the final word transfers
//   buf_en/buf_addr                : read request to buffer port B
//   buf_rdata                      : read data from buffer port B
//   m_valid/m_data/m_last/m_ready  : output stream
//   perf_stall_cnt                 : (ACT_STREAM_PERF_EN) cycles with m_valid && !m_ready
//   perf_starve_cnt                : (ACT_STREAM_PERF_EN) RUN cycles with FIFO empty, reads left
// ---------------------------------------------------------------------------------------------
module act_buf_stream_ctrl
    import act_buf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ACT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = ACT_ADDR_WIDTH,
    parameter int unsigned CNT_W      = ACT_CNT_W,
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [CNT_W-1:0]      cfg_count,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  buf_en,
    output logic [ADDR_WIDTH-1:0] buf_addr,
    input  logic [DATA_WIDTH-1:0] buf_rdata,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
`ifdef ACT_STREAM_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_starve_cnt
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]      DepthCmp = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]    InfOne   = CW'(1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    act_stream_state_e r_state;
    act_stream_state_e w_state_d;

    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic [CNT_W-1:0]      r_issued;
    logic [CNT_W-1:0]      r_accepted;
    logic [CW-1:0]         r_inflight;
    logic [CW-1:0]         w_inflight_d;
    logic [READ_LAT-1:0]   r_vpipe;
    logic                  r_buf_en;
    logic [ADDR_WIDTH-1:0] r_buf_addr;
    logic                  r_done;
    logic                  w_done_d;

    logic                  w_start;
    logic                  w_start_run;
    logic                  w_abort;
    logic                  w_xfer;
    logic                  w_last_xfer;
    logic                  w_capture;
    logic                  w_credit_ok;
    logic                  w_issue;
    logic                  w_push;

    logic [DATA_WIDTH-1:0] w_fifo_rdata;
    logic [CW-1:0]         w_fifo_count;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;

    // ------------------------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------------------------
    always_comb begin
        w_start     = cfg_start && (r_state == StIdle);
        w_start_run = w_start && (cfg_count != '0);
        w_abort     = abort && (r_state == StRun);
        w_xfer      = m_valid && m_ready;
        w_last_xfer = w_xfer && m_last;
        // The valid pipe marks the cycle in which buf_rdata holds the word for an earlier read.
        w_capture   = r_vpipe[READ_LAT-1];
        // Every outstanding read owns a FIFO slot, so capture can never overflow the FIFO.
        w_credit_ok = !w_fifo_full &&
                      (({1'b0, w_fifo_count} + {1'b0, r_inflight}) < DepthCmp);
        w_issue     = (r_state == StRun) && !abort && (r_issued < r_count) && w_credit_ok;
        // Words landing during FLUSH or in the abort cycle are discarded.
        w_push      = w_capture && (r_state == StRun) && !abort;
    end

    always_comb begin
        w_inflight_d = r_inflight;
        if (w_issue && !w_capture) begin
            w_inflight_d = r_inflight + InfOne;
        end else if (!w_issue && w_capture) begin
            w_inflight_d = r_inflight - InfOne;
        end
    end

    // ------------------------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state;
        w_done_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_start_run) begin
                    w_state_d = StRun;
                end else if (w_start) begin
                    w_done_d = 1'b1;
                end
            end
            StRun: begin
                if (abort) begin
                    w_state_d = StFlush;
                end else if (w_last_xfer) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end
            end
            StFlush: begin
                if (w_inflight_d == '0) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_done  <= w_done_d;
        end
    end

    // ------------------------------------------------------------------------------------------
    // Descriptor, issue side and read-valid pipe
    // ------------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_stride    <= '0;
            r_next_addr <= '0;
            r_issued    <= '0;
            r_accepted  <= '0;
            r_buf_en    <= 1'b0;
            r_buf_addr  <= '0;
        end else begin
            r_buf_en <= w_issue;
            if (w_start_run) begin
                r_count     <= cfg_count;
                r_stride    <= cfg_stride;
                r_next_addr <= cfg_base;
                r_issued    <= '0;
                r_accepted  <= '0;
            end else begin
                if (w_issue) begin
                    r_buf_addr  <= r_next_addr;
                    r_next_addr <= r_next_addr + r_stride;
                    r_issued    <= r_issued + CntOne;
                end
                if (w_xfer && (r_state == StRun)) begin
                    r_accepted <= r_accepted + CntOne;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vpipe    <= '0;
            r_inflight <= '0;
        end else begin
            r_vpipe[0] <= r_buf_en;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
            r_inflight <= w_inflight_d;
        end
    end

    // ------------------------------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------------------------------
    act_stream_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_abort),
        .i_push  (w_push),
        .i_pop   (w_xfer),
        .i_wdata (buf_rdata),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign busy     = (r_state != StIdle);
    assign done     = r_done;
    assign buf_en   = r_buf_en;
    assign buf_addr = r_buf_addr;
    assign m_valid  = !w_fifo_empty;
    assign m_data   = w_fifo_rdata;
    // The head is always word number r_accepted of the stream.
    assign m_last   = m_valid && (r_accepted == (r_count - CntOne));

`ifdef ACT_STREAM_PERF_EN
    // ------------------------------------------------------------------------------------------
    // Performance counters (saturating)
    // ------------------------------------------------------------------------------------------
    logic [31:0] r_stall_cnt;
    logic [31:0] r_starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_starve_cnt <= '0;
        end else if (w_start) begin
            r_stall_cnt  <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (m_valid && !m_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if ((r_state == StRun) && w_fifo_empty && (r_issued < r_count) &&
                (r_starve_cnt != '1)) begin
                r_starve_cnt <= r_starve_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt  = r_stall_cnt;
    assign perf_starve_cnt = r_starve_cnt;
`endif

endmodule
